// File: rtl/ps2_key_packer.sv
// Assembles PS/2 scancode bytes (E0/F0/E1 prefixes) into 11-bit key events
// with a toggle bit, and abandons stalled partial sequences after TIMEOUT cycles.
module ps2_key_packer #(
  parameter int unsigned TIMEOUT = 24576
) (
  input  logic        clk_sys,
  input  logic        I_RESETn,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        seq_timeout
);

  localparam int unsigned TMO_W  = 16;
  localparam int unsigned SKIP_W = 3;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_e;

  state_e             state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [10:0]        key_q;
  logic               stb_q, tmo_pulse_q;
  logic               expire_c, emit_c, pressed_c, ext_c;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire_c = (state_q != S_IDLE) && !byte_valid && (tmo_q == TMO_LAST);

  // State and counter registers
  always_ff @(posedge clk_sys) begin
    if (!I_RESETn) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = (state_q == S_IDLE || byte_valid || expire_c) ? '0 : tmo_q + TMO_W'(1);
    if (byte_valid) begin
      case (state_q)
        S_IDLE: begin
          case (byte_in)
            8'hE0:   state_d = S_EXT;
            8'hF0:   state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = SKIP_W'(7);
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_EXT: begin
          case (byte_in)
            8'hF0:   state_d = S_EXT_BRK;
            8'hE0:   state_d = S_EXT;
            default: state_d = S_IDLE;
          endcase
        end
        S_PAUSE: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q <= SKIP_W'(1)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire_c) begin
      state_d = S_IDLE;
      skip_d  = '0;
    end
  end

  // Event decode for the current byte
  always_comb begin
    emit_c    = 1'b0;
    pressed_c = 1'b0;
    ext_c     = 1'b0;
    if (byte_valid) begin
      case (state_q)
        S_IDLE: begin
          case (byte_in)
            8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: emit_c = 1'b0;
            default: begin
              emit_c    = 1'b1;
              pressed_c = 1'b1;
            end
          endcase
        end
        S_EXT: begin
          case (byte_in)
            8'hF0, 8'hE0, 8'h12: emit_c = 1'b0;
            default: begin
              emit_c    = 1'b1;
              pressed_c = 1'b1;
              ext_c     = 1'b1;
            end
          endcase
        end
        S_BRK:     emit_c = 1'b1;
        S_EXT_BRK: begin
          emit_c = (byte_in != 8'h12);
          ext_c  = 1'b1;
        end
        default:   emit_c = 1'b0;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk_sys) begin
    if (!I_RESETn) begin
      key_q       <= '0;
      stb_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      stb_q       <= emit_c;
      tmo_pulse_q <= expire_c;
      if (emit_c) key_q <= {~key_q[10], pressed_c, ext_c, byte_in};
    end
  end

  assign ps2_key     = key_q;
  assign key_stb     = stb_q;
  assign seq_timeout = tmo_pulse_q;

endmodule
